// File: rtl/decompressor_if.sv
// Flit stream bundle for the decompressor: upstream input handshake, downstream output handshake
// and the protocol-error counter.
interface decomp_if #(
    parameter int INPUT_WIDTH  = 128,
    parameter int OUTPUT_WIDTH = 128
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    is_head;
    logic                    is_tail;
    logic [INPUT_WIDTH-1:0]  data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_head;
    logic [OUTPUT_WIDTH-1:0] data_out;
    logic [7:0]              err_count;

    modport master (
        output in_valid, is_head, is_tail, data_in, out_ready,
        input  in_ready, out_valid, out_head, data_out, err_count
    );

    modport slave (
        input  in_valid, is_head, is_tail, data_in, out_ready,
        output in_ready, out_valid, out_head, data_out, err_count
    );
endinterface

// File: rtl/decompressor.sv
// Delta decompressor: restores head flits and rebuilds body flits from per-chunk deltas plus a base.
// Optional macro DECOMP_ERR_CNT_EN enables the saturating protocol-error counter.
module decompressor #(
    parameter int INPUT_WIDTH  = 128,
    parameter int OUTPUT_WIDTH = 128,
    parameter int CHUNK_SIZE   = 8,
    parameter int EN_BITS      = 3,
    parameter int META_MSB     = 74
) (
    input  logic     clk_in,
    input  logic     rst_n,
    decomp_if.slave  bus
);
    localparam int N_CHUNKS = INPUT_WIDTH / CHUNK_SIZE;
    localparam int META_LSB = META_MSB - EN_BITS - CHUNK_SIZE + 1;
    localparam int BASE_MSB = META_LSB + CHUNK_SIZE - 1;

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_GEN} state_t;

    state_t                  r_state;
    logic [EN_BITS-1:0]      r_en_bits;
    logic [CHUNK_SIZE-1:0]   r_base;
    logic                    r_out_valid;
    logic                    r_out_head;
    logic [OUTPUT_WIDTH-1:0] r_data_out;

    logic                    w_in_ready;
    logic                    w_acc;
    logic [CHUNK_SIZE-1:0]   w_offset;
    logic [OUTPUT_WIDTH-1:0] w_decoded;
    logic [OUTPUT_WIDTH-1:0] w_head_out;
    logic [EN_BITS-1:0]      w_new_en;

    // Reset gates ready so nothing is accepted while rst_n is held low.
    assign w_in_ready = rst_n && (r_state != S_GEN) && (!r_out_valid || bus.out_ready);
    assign w_acc      = bus.in_valid && w_in_ready;
    assign w_new_en   = bus.data_in[META_MSB -: EN_BITS];
    assign w_offset   = (r_en_bits == '1) ? '0 : r_base;

    always_comb begin
        w_decoded = '0;
        for (int i = 0; i < N_CHUNKS; i++) begin
            w_decoded[i*CHUNK_SIZE +: CHUNK_SIZE] = bus.data_in[i*CHUNK_SIZE +: CHUNK_SIZE] + w_offset;
        end
    end

    always_comb begin
        w_head_out = bus.data_in;
        w_head_out[META_MSB:META_LSB] = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_en_bits   <= '0;
            r_base      <= '0;
            r_out_valid <= 1'b0;
            r_out_head  <= 1'b0;
            r_data_out  <= '0;
        end else begin
            if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_BODY: begin
                    if (w_acc) begin
                        if (bus.is_head) begin
                            r_en_bits   <= w_new_en;
                            r_base      <= bus.data_in[BASE_MSB:META_LSB];
                            r_data_out  <= w_head_out;
                            r_out_valid <= 1'b1;
                            r_out_head  <= 1'b1;
                            r_state     <= (w_new_en == '0) ? S_GEN : S_BODY;
                        end else if (r_state == S_BODY) begin
                            r_data_out  <= w_decoded;
                            r_out_valid <= 1'b1;
                            r_out_head  <= 1'b0;
                            if (bus.is_tail) r_state <= S_IDLE;
                        end
                    end
                end
                S_GEN: begin
                    // Synthesized body replaces the head once the head has left the register.
                    if (!r_out_valid || bus.out_ready) begin
                        r_data_out  <= {N_CHUNKS{r_base}};
                        r_out_valid <= 1'b1;
                        r_out_head  <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_head  = r_out_head;
    assign bus.data_out  = r_data_out;

`ifdef DECOMP_ERR_CNT_EN
    logic       w_err;
    logic [7:0] r_err_count;

    assign w_err = w_acc && (((r_state == S_IDLE) && !bus.is_head) ||
                             ((r_state == S_BODY) &&  bus.is_head));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_decompressor.sv
// Directed self-checking bench for the decompressor; expected values are hand-computed constants.
module tb_decompressor;
`ifdef DECOMP_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk_in;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    decomp_if #(.INPUT_WIDTH(128), .OUTPUT_WIDTH(128)) bus ();

    decompressor dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic h, input logic t, input logic [127:0] d);
        @(negedge clk_in);
        bus.in_valid = 1'b1;
        bus.is_head  = h;
        bus.is_tail  = t;
        bus.data_in  = d;
        @(posedge clk_in);
        #1;
        bus.in_valid = 1'b0;
        bus.is_head  = 1'b0;
        bus.is_tail  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk_in);
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [127:0] mk_head(input logic [127:0] payload, input logic [2:0] en, input logic [7:0] base);
        logic [127:0] h;
        h = payload;
        h[74:64] = {en, base};
        return h;
    endfunction

    function automatic logic [127:0] strip(input logic [127:0] h);
        logic [127:0] s;
        s = h;
        s[74:64] = 11'h0;
        return s;
    endfunction

    logic [127:0] h;
    logic [127:0] pay;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pay      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.is_head   = 1'b0;
        bus.is_tail   = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_head",  bus.out_head,  0);
        chk("rst_data_out",  bus.data_out,  0);
        chk("rst_err",       bus.err_count, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // head en=2 base=40, tail body deltas 05 -> 45
        h = mk_head(pay, 3'b010, 8'h40);
        drive(1'b1, 1'b0, h);
        chk("t1_head_valid", bus.out_valid, 1);
        chk("t1_head_flag",  bus.out_head,  1);
        chk("t1_head_data",  bus.data_out,  strip(h));
        drive(1'b0, 1'b1, {16{8'h05}});
        chk("t1_body_valid", bus.out_valid, 1);
        chk("t1_body_flag",  bus.out_head,  0);
        chk("t1_body_data",  bus.data_out,  {16{8'h45}});
        idle_cycle();
        chk("t1_drained", bus.out_valid, 0);

        // en=0 base=A4 -> synthesized body, in_ready low in GEN
        h = mk_head(pay, 3'b000, 8'hA4);
        drive(1'b1, 1'b0, h);
        chk("t2_head_data",  bus.data_out, strip(h));
        chk("t2_head_flag",  bus.out_head, 1);
        chk("t2_gen_ready",  bus.in_ready, 0);
        idle_cycle();
        chk("t2_gen_valid",  bus.out_valid, 1);
        chk("t2_gen_flag",   bus.out_head,  0);
        chk("t2_gen_data",   bus.data_out,  {16{8'hA4}});
        chk("t2_idle_ready", bus.in_ready,  1);
        idle_cycle();

        // en=111 -> offset 0
        drive(1'b1, 1'b0, mk_head(pay, 3'b111, 8'h33));
        drive(1'b0, 1'b1, {16{8'hFF}});
        chk("t3_off0_data", bus.data_out, {16{8'hFF}});
        // wrap-around FF+02 = 01, and a mixed-delta tail flit
        drive(1'b1, 1'b0, mk_head(pay, 3'b001, 8'h02));
        drive(1'b0, 1'b0, {16{8'hFF}});
        chk("t3_wrap_data", bus.data_out, {16{8'h01}});
        drive(1'b0, 1'b1, 128'h00010203_04050607_08090A0B_0C0D0EFE);
        chk("t3_mixed_data", bus.data_out, 128'h02030405_06070809_0A0B0C0D_0E0F1000);
        idle_cycle();

        // back-pressure mid-stream, base 10
        drive(1'b1, 1'b0, mk_head(pay, 3'b001, 8'h10));
        drive(1'b0, 1'b0, {16{8'h01}});
        chk("t4_f1_data", bus.data_out, {16{8'h11}});
        @(negedge clk_in);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = {16{8'h02}};
        #1;
        chk("t4_stall_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            chk("t4_hold_valid", bus.out_valid, 1);
            chk("t4_hold_data",  bus.data_out,  {16{8'h11}});
        end
        @(negedge clk_in);
        bus.out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        chk("t4_f2_data", bus.data_out, {16{8'h12}});
        @(negedge clk_in);
        bus.is_tail = 1'b1;
        bus.data_in = {16{8'h03}};
        @(posedge clk_in);
        #1;
        bus.in_valid = 1'b0;
        bus.is_tail  = 1'b0;
        chk("t4_f3_data", bus.data_out, {16{8'h13}});
        idle_cycle();
        chk("t4_drained", bus.out_valid, 0);

        // protocol errors: body in IDLE, then head during BODY
        drive(1'b0, 1'b0, {16{8'h77}});
        chk("t5_drop_valid", bus.out_valid, 0);
        chk("t5_err1", bus.err_count, ERR_EN ? 8'd1 : 8'd0);
        drive(1'b1, 1'b0, mk_head(pay, 3'b001, 8'h00));
        h = mk_head(pay, 3'b010, 8'h40);
        drive(1'b1, 1'b1, h);
        chk("t5_rehead_flag", bus.out_head, 1);
        chk("t5_rehead_data", bus.data_out, strip(h));
        chk("t5_err2", bus.err_count, ERR_EN ? 8'd2 : 8'd0);
        drive(1'b0, 1'b1, {16{8'h01}});
        chk("t5_newmeta_data", bus.data_out, {16{8'h41}});
        idle_cycle();

        // asynchronous reset while BODY holds an output flit
        drive(1'b1, 1'b0, mk_head(pay, 3'b001, 8'h02));
        drive(1'b0, 1'b0, {16{8'h00}});
        chk("t6_pre_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", bus.out_valid, 0);
        chk("t6_async_data",  bus.data_out,  0);
        chk("t6_async_err",   bus.err_count, 0);
        chk("t6_async_ready", bus.in_ready,  0);
        @(negedge clk_in);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, {16{8'h05}});
        chk("t6_idle_drop", bus.out_valid, 0);
        drive(1'b1, 1'b0, mk_head(pay, 3'b011, 8'h20));
        drive(1'b0, 1'b1, {16{8'h05}});
        chk("t6_recover_data", bus.data_out, {16{8'h25}});
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decompressor.md
DECOMPRESSOR -- requirements
Module: decompressor

Interface
REQ-001 INPUT_WIDTH, 128, input flit width in bits.
REQ-002 OUTPUT_WIDTH, 128, output flit width in bits.
REQ-003 CHUNK_SIZE, 8, chunk width in bits (16 chunks per flit).
REQ-004 EN_BITS, 3, encoded-range field width in bits.
REQ-005 META_MSB, 74, MSB of the head-flit metadata field {en_bits,base} occupying bits [74:64].
REQ-006 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  data_in/is_head/is_tail are valid this cycle.
REQ-009 in_ready  output  1  block accepts the input flit this cycle.
REQ-010 is_head  input  1  input flit is a head flit carrying metadata.
REQ-011 is_tail  input  1  input flit is the last compressed body flit of the packet.
REQ-012 data_in  input  INPUT_WIDTH  head flit, or 16 packed deltas with chunk 1 in the MSBs.
REQ-013 out_valid  output  1  data_out holds a reconstructed flit.
REQ-014 out_ready  input  1  downstream consumes data_out this cycle.
REQ-015 out_head  output  1  data_out is the restored head flit.
REQ-016 data_out  output  OUTPUT_WIDTH  reconstructed flit.
REQ-017 err_count  output  8  protocol-error counter (see Configuration).

Function
REQ-018 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-019 Output is a single register stage; in_ready = (state!=GEN) && (!out_valid || out_ready).
REQ-020 States: IDLE (await head), BODY (decoding deltas), GEN (emitting synthesized body).
REQ-021 IDLE + accepted head: latch en_bits=data_in[74:72], base=data_in[71:64]; emit head with bits [74:64] zeroed and out_head=1 the next cycle; go to GEN if en_bits==0, else BODY.
REQ-022 GEN: once the head flit is consumed, load a body flit of 16 copies of base with out_head=0; return to IDLE when that flit is loaded; in_ready=0 throughout GEN.
REQ-023 BODY + accepted non-head flit: chunk_i = (delta_i + offset) mod 2^CHUNK_SIZE, where offset=0 if en_bits==3'b111, else base; result registered with 1-cycle latency, out_head=0.
REQ-024 BODY + accepted flit with is_tail=1: decode per REQ-023, then go to IDLE.
REQ-025 Head accepted while in BODY: counts as one protocol error; the new metadata replaces the old; REQ-021 applies.
REQ-026 Non-head flit accepted in IDLE: dropped, no output, counts as one protocol error.
REQ-027 is_head and is_tail both set: is_head wins; is_tail is ignored.
REQ-028 Output back-pressure: out_valid and data_out hold stable until consumed; no flit is lost or duplicated.
REQ-029 Full-throughput: with out_ready held high, one body flit per cycle is sustained.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, out_valid=0, out_head=0, data_out=0, en_bits=0, base=0, err_count=0.
REQ-031 Reset mid-packet discards the packet and any held output flit; the first flit accepted after reset release must be a head flit.
REQ-032 in_ready is 0 while rst_n is low and is 1 in the first cycle after release.

Configuration
REQ-033 Macro DECOMP_ERR_CNT_EN defined: err_count increments by 1 per protocol error (REQ-025, REQ-026) and saturates at 255.
REQ-034 Macro DECOMP_ERR_CNT_EN undefined: err_count is constant 0, no counter logic exists, and all other behaviour is identical.

Verification
REQ-035 Head with [74:64]={3'b010,8'h40}, then tail body with all deltas 8'h05 -> head output with [74:64]=0 and out_head=1, then body output of all chunks 8'h45.
REQ-036 Head with en_bits=0 and base=8'hA4 -> head output, then one synthesized body flit 128'hA4A4...A4, state IDLE, in_ready=0 until GEN exits.
REQ-037 Head with en_bits=3'b111, then body with deltas 8'hFF -> output chunks 8'hFF (offset 0); en_bits=3'b001, base=8'h02, delta 8'hFF -> output chunks 8'h01 (wrap-around).
REQ-038 Three body flits with out_ready low for 3 cycles mid-stream -> in_ready drops, data_out held stable, all three flits delivered in order.
REQ-039 Body flit in IDLE, then head while in BODY -> err_count=2 with DECOMP_ERR_CNT_EN defined, 0 without; no output for the dropped flit.
REQ-040 rst_n pulsed low while in BODY with out_valid=1 -> out_valid=0 immediately (asynchronous), state IDLE, err_count=0.
